// File: rtl/ls_queue_pkg.sv
// Shared constants and types for the load/store queue.
package ls_queue_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ROB_WIDTH  = 5;

  localparam logic [ROB_WIDTH-1:0] ZERO_ROB = '0;

  // funct3 encodings for loads and stores
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  // Memory access size codes (equal to funct3[1:0])
  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

  typedef enum logic {
    LSQ_IDLE,
    LSQ_WAIT_MEM
  } lsq_state_e;

  // One queue slot
  typedef struct packed {
    logic                  valid;
    logic                  is_store;
    logic                  committed;
    logic [2:0]            funct3;
    logic [ROB_WIDTH-1:0]  rob_tag;
    logic [ROB_WIDTH-1:0]  base_tag;
    logic [DATA_WIDTH-1:0] base_val;
    logic [ROB_WIDTH-1:0]  data_tag;
    logic [DATA_WIDTH-1:0] data_val;
    logic [DATA_WIDTH-1:0] imm;
  } lsq_entry_t;

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of raw load data according to funct3.
module load_extend
  import ls_queue_pkg::*;
(
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] raw,
  output logic [DATA_WIDTH-1:0] data_ext_c
);

  // Select extension mode; LW and anything else pass through
  always_comb begin
    data_ext_c = raw;
    case (funct3)
      F3_LB:   data_ext_c = {{(DATA_WIDTH-8){raw[7]}}, raw[7:0]};
      F3_LH:   data_ext_c = {{(DATA_WIDTH-16){raw[15]}}, raw[15:0]};
      F3_LBU:  data_ext_c = DATA_WIDTH'(raw[7:0]);
      F3_LHU:  data_ext_c = DATA_WIDTH'(raw[15:0]);
      default: data_ext_c = raw;
    endcase
  end

endmodule

// File: rtl/ls_queue.sv
// In-order load/store queue: circular FIFO, CDB snooping, single outstanding memory access.
module ls_queue
  import ls_queue_pkg::*;
#(
  parameter int unsigned LSQ_SIZE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  in_assign_ena,
  input  logic                  in_is_store,
  input  logic [2:0]            in_funct3,
  input  logic [ROB_WIDTH-1:0]  in_rob_tag,
  input  logic [ROB_WIDTH-1:0]  in_base_tag,
  input  logic [DATA_WIDTH-1:0] in_base_value,
  input  logic [ROB_WIDTH-1:0]  in_data_tag,
  input  logic [DATA_WIDTH-1:0] in_data_value,
  input  logic [DATA_WIDTH-1:0] in_imm,
  output logic                  out_lsq_ok,
  input  logic [ROB_WIDTH-1:0]  in_cdb_rob_tag,
  input  logic [DATA_WIDTH-1:0] in_cdb_value,
  input  logic [ROB_WIDTH-1:0]  in_committed_rob_tag,
  input  logic                  in_misbranch,
  output logic                  out_mem_req,
  output logic                  out_mem_we,
  output logic [DATA_WIDTH-1:0] out_mem_addr,
  output logic [DATA_WIDTH-1:0] out_mem_data,
  output logic [1:0]            out_mem_size,
  input  logic                  in_mem_done,
  input  logic [DATA_WIDTH-1:0] in_mem_rdata,
  output logic [ROB_WIDTH-1:0]  out_ls_cdb_rob_tag,
  output logic [DATA_WIDTH-1:0] out_ls_cdb_value
);

  localparam int unsigned IDX_W = $clog2(LSQ_SIZE);
  localparam int unsigned CNT_W = IDX_W + 1;

  lsq_entry_t          q [LSQ_SIZE];
  logic [IDX_W-1:0]    head, tail;
  logic [CNT_W-1:0]    count;
  lsq_state_e          state, state_nxt;

  logic                inflight_store;
  logic [2:0]          inflight_f3;
  logic                killed;

  lsq_entry_t          head_e, new_entry_c;
  logic                head_ready_c, issue_c, done_c;
  logic                push_c, pop_c, bcast_c;
  logic [CNT_W-1:0]    keep_cnt_c;
  logic [LSQ_SIZE-1:0] keep_c;
  logic [IDX_W-1:0]    scan_idx;
  logic                scan_run;
  logic [DATA_WIDTH-1:0] ext_c;

  function automatic logic tag_hit(input logic [ROB_WIDTH-1:0] t, input logic [ROB_WIDTH-1:0] c);
    return (t != ZERO_ROB) && (t == c);
  endfunction

  assign out_lsq_ok = (count < CNT_W'(LSQ_SIZE - 1));

  load_extend u_load_extend (
    .funct3     (inflight_f3),
    .raw        (in_mem_rdata),
    .data_ext_c (ext_c)
  );

  // FSM next state plus issue/completion strobes
  always_comb begin
    state_nxt    = state;
    issue_c      = 1'b0;
    done_c       = 1'b0;
    head_e       = q[head];
    head_ready_c = (count != '0) && head_e.valid && (head_e.base_tag == ZERO_ROB) &&
                   (!head_e.is_store || ((head_e.data_tag == ZERO_ROB) && head_e.committed));
    case (state)
      LSQ_IDLE: begin
        if (head_ready_c && !in_misbranch) begin
          issue_c   = 1'b1;
          state_nxt = LSQ_WAIT_MEM;
        end
      end
      LSQ_WAIT_MEM: begin
        if (in_mem_done) begin
          done_c    = 1'b1;
          state_nxt = LSQ_IDLE;
        end
      end
      default: state_nxt = LSQ_IDLE;
    endcase
  end

  // Queue bookkeeping strobes; a flushed load completes silently
  always_comb begin
    push_c  = in_assign_ena && !in_misbranch && (count < CNT_W'(LSQ_SIZE));
    pop_c   = done_c && !killed && (inflight_store || !in_misbranch);
    bcast_c = done_c && !killed && !inflight_store && !in_misbranch;
  end

  // Count contiguous committed stores from head; they survive a flush
  always_comb begin
    keep_cnt_c = '0;
    scan_run   = 1'b1;
    scan_idx   = '0;
    for (int j = 0; j < LSQ_SIZE; j++) begin
      scan_idx = head + IDX_W'(j);
      if (scan_run && (CNT_W'(j) < count) && q[scan_idx].valid &&
          q[scan_idx].is_store && q[scan_idx].committed)
        keep_cnt_c = keep_cnt_c + CNT_W'(1);
      else
        scan_run = 1'b0;
    end
    for (int i = 0; i < LSQ_SIZE; i++)
      keep_c[i] = CNT_W'(IDX_W'(IDX_W'(i) - head)) < keep_cnt_c;
  end

  // Incoming entry, with same-cycle CDB capture of its operands
  always_comb begin
    new_entry_c          = '0;
    new_entry_c.valid    = 1'b1;
    new_entry_c.is_store = in_is_store;
    new_entry_c.funct3   = in_funct3;
    new_entry_c.rob_tag  = in_rob_tag;
    new_entry_c.base_tag = in_base_tag;
    new_entry_c.base_val = in_base_value;
    new_entry_c.data_tag = in_data_tag;
    new_entry_c.data_val = in_data_value;
    new_entry_c.imm      = in_imm;
    if (tag_hit(in_base_tag, in_cdb_rob_tag)) begin
      new_entry_c.base_tag = ZERO_ROB;
      new_entry_c.base_val = in_cdb_value;
    end else if (tag_hit(in_base_tag, out_ls_cdb_rob_tag)) begin
      new_entry_c.base_tag = ZERO_ROB;
      new_entry_c.base_val = out_ls_cdb_value;
    end
    if (tag_hit(in_data_tag, in_cdb_rob_tag)) begin
      new_entry_c.data_tag = ZERO_ROB;
      new_entry_c.data_val = in_cdb_value;
    end else if (tag_hit(in_data_tag, out_ls_cdb_rob_tag)) begin
      new_entry_c.data_tag = ZERO_ROB;
      new_entry_c.data_val = out_ls_cdb_value;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     state <= LSQ_IDLE;
    else if (ena) state <= state_nxt;
  end

  // Entry storage: snoop, commit, flush, pop, push and pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < LSQ_SIZE; i++) q[i] <= '0;
    end else if (ena) begin
      for (int i = 0; i < LSQ_SIZE; i++) begin
        if (tag_hit(q[i].base_tag, in_cdb_rob_tag)) begin
          q[i].base_tag <= ZERO_ROB;
          q[i].base_val <= in_cdb_value;
        end else if (tag_hit(q[i].base_tag, out_ls_cdb_rob_tag)) begin
          q[i].base_tag <= ZERO_ROB;
          q[i].base_val <= out_ls_cdb_value;
        end
        if (tag_hit(q[i].data_tag, in_cdb_rob_tag)) begin
          q[i].data_tag <= ZERO_ROB;
          q[i].data_val <= in_cdb_value;
        end else if (tag_hit(q[i].data_tag, out_ls_cdb_rob_tag)) begin
          q[i].data_tag <= ZERO_ROB;
          q[i].data_val <= out_ls_cdb_value;
        end
        if (q[i].valid && q[i].is_store && tag_hit(q[i].rob_tag, in_committed_rob_tag))
          q[i].committed <= 1'b1;
        if (in_misbranch && !keep_c[i]) begin
          q[i].valid     <= 1'b0;
          q[i].committed <= 1'b0;
        end
      end
      if (pop_c) begin
        q[head].valid     <= 1'b0;
        q[head].committed <= 1'b0;
      end
      if (push_c) q[tail] <= new_entry_c;
      head <= head + IDX_W'(pop_c);
      if (in_misbranch) begin
        tail  <= head + IDX_W'(keep_cnt_c);
        count <= keep_cnt_c - CNT_W'(pop_c);
      end else begin
        tail  <= tail + IDX_W'(push_c);
        count <= count + CNT_W'(push_c) - CNT_W'(pop_c);
      end
    end
  end

  // Memory request registers and load result broadcast
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_mem_req        <= 1'b0;
      out_mem_we         <= 1'b0;
      out_mem_addr       <= '0;
      out_mem_data       <= '0;
      out_mem_size       <= '0;
      out_ls_cdb_rob_tag <= ZERO_ROB;
      out_ls_cdb_value   <= '0;
      inflight_store     <= 1'b0;
      inflight_f3        <= '0;
      killed             <= 1'b0;
    end else if (ena) begin
      out_ls_cdb_rob_tag <= ZERO_ROB;
      out_ls_cdb_value   <= '0;
      if (issue_c) begin
        out_mem_req    <= 1'b1;
        out_mem_we     <= head_e.is_store;
        out_mem_addr   <= head_e.base_val + head_e.imm;
        out_mem_data   <= head_e.data_val;
        out_mem_size   <= head_e.funct3[1:0];
        inflight_store <= head_e.is_store;
        inflight_f3    <= head_e.funct3;
        killed         <= 1'b0;
      end else if (done_c) begin
        out_mem_req <= 1'b0;
        killed      <= 1'b0;
      end else if (in_misbranch && (state == LSQ_WAIT_MEM) && !inflight_store) begin
        killed <= 1'b1;
      end
      if (bcast_c) begin
        out_ls_cdb_rob_tag <= head_e.rob_tag;
        out_ls_cdb_value   <= ext_c;
      end
    end
  end

endmodule

// File: tb/tb_ls_queue.sv
// Directed self-checking bench for ls_queue.
module tb_ls_queue;
  import ls_queue_pkg::*;

  logic                  clk, rst, ena;
  logic                  in_assign_ena, in_is_store;
  logic [2:0]            in_funct3;
  logic [ROB_WIDTH-1:0]  in_rob_tag, in_base_tag, in_data_tag;
  logic [DATA_WIDTH-1:0] in_base_value, in_data_value, in_imm;
  logic                  out_lsq_ok;
  logic [ROB_WIDTH-1:0]  in_cdb_rob_tag, in_committed_rob_tag;
  logic [DATA_WIDTH-1:0] in_cdb_value;
  logic                  in_misbranch;
  logic                  out_mem_req, out_mem_we;
  logic [DATA_WIDTH-1:0] out_mem_addr, out_mem_data;
  logic [1:0]            out_mem_size;
  logic                  in_mem_done;
  logic [DATA_WIDTH-1:0] in_mem_rdata;
  logic [ROB_WIDTH-1:0]  out_ls_cdb_rob_tag;
  logic [DATA_WIDTH-1:0] out_ls_cdb_value;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_count = 0;

  ls_queue #(.LSQ_SIZE(16)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .in_assign_ena(in_assign_ena), .in_is_store(in_is_store), .in_funct3(in_funct3),
    .in_rob_tag(in_rob_tag), .in_base_tag(in_base_tag), .in_base_value(in_base_value),
    .in_data_tag(in_data_tag), .in_data_value(in_data_value), .in_imm(in_imm),
    .out_lsq_ok(out_lsq_ok), .in_cdb_rob_tag(in_cdb_rob_tag), .in_cdb_value(in_cdb_value),
    .in_committed_rob_tag(in_committed_rob_tag), .in_misbranch(in_misbranch),
    .out_mem_req(out_mem_req), .out_mem_we(out_mem_we), .out_mem_addr(out_mem_addr),
    .out_mem_data(out_mem_data), .out_mem_size(out_mem_size),
    .in_mem_done(in_mem_done), .in_mem_rdata(in_mem_rdata),
    .out_ls_cdb_rob_tag(out_ls_cdb_rob_tag), .out_ls_cdb_value(out_ls_cdb_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Completed memory writes
  always @(posedge clk)
    if (rst && out_mem_req && in_mem_done && out_mem_we) wr_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_assign_ena = 0; in_is_store = 0; in_funct3 = '0; in_rob_tag = '0;
    in_base_tag = '0; in_base_value = '0; in_data_tag = '0; in_data_value = '0;
    in_imm = '0; in_cdb_rob_tag = '0; in_cdb_value = '0; in_committed_rob_tag = '0;
    in_misbranch = 0; in_mem_done = 0; in_mem_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 0;
    tick();
    rst = 1;
    tick();
  endtask

  task automatic dispatch(input logic st, input logic [2:0] f3, input logic [ROB_WIDTH-1:0] rob,
                          input logic [ROB_WIDTH-1:0] btag, input logic [31:0] bval,
                          input logic [ROB_WIDTH-1:0] dtag, input logic [31:0] dval,
                          input logic [31:0] imm);
    in_assign_ena = 1; in_is_store = st; in_funct3 = f3; in_rob_tag = rob;
    in_base_tag = btag; in_base_value = bval; in_data_tag = dtag; in_data_value = dval;
    in_imm = imm;
    tick();
    in_assign_ena = 0;
  endtask

  task automatic respond(input logic [31:0] d);
    in_mem_done = 1; in_mem_rdata = d;
    tick();
    in_mem_done = 0; in_mem_rdata = '0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!out_mem_req && n < 10) begin
      tick();
      n++;
    end
    check("req_wait", 32'(out_mem_req), 32'd1);
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [ROB_WIDTH-1:0] rob,
                         input logic [31:0] rdata, input logic [31:0] exp, input string tag);
    dispatch(0, f3, rob, '0, 32'h40, '0, '0, 32'h0);
    tick();
    check({tag, "_req"}, 32'(out_mem_req), 32'd1);
    respond(rdata);
    check({tag, "_tag"}, 32'(out_ls_cdb_rob_tag), 32'(rob));
    check({tag, "_val"}, out_ls_cdb_value, exp);
  endtask

  initial begin
    ena = 1;
    clear_inputs();
    rst = 0;
    tick();
    tick();
    // Reset state while held in reset
    check("rst_req",   32'(out_mem_req), 32'd0);
    check("rst_we",    32'(out_mem_we), 32'd0);
    check("rst_addr",  out_mem_addr, 32'd0);
    check("rst_size",  32'(out_mem_size), 32'd0);
    check("rst_cdbt",  32'(out_ls_cdb_rob_tag), 32'd0);
    check("rst_cdbv",  out_ls_cdb_value, 32'd0);
    check("rst_ok",    32'(out_lsq_ok), 32'd1);
    check("rst_count", 32'(dut.count), 32'd0);
    rst = 1;
    tick();

    // LW with 2-cycle memory latency
    dispatch(0, F3_LW, 5'd3, '0, 32'h100, '0, '0, 32'd4);
    check("lw_count", 32'(dut.count), 32'd1);
    tick();
    check("lw_req",  32'(out_mem_req), 32'd1);
    check("lw_addr", out_mem_addr, 32'h104);
    check("lw_size", 32'(out_mem_size), 32'd2);
    check("lw_we",   32'(out_mem_we), 32'd0);
    tick();
    tick();
    check("lw_hold", 32'(out_mem_req), 32'd1);
    respond(32'hDEADBEEF);
    check("lw_cdbt", 32'(out_ls_cdb_rob_tag), 32'd3);
    check("lw_cdbv", out_ls_cdb_value, 32'hDEADBEEF);
    check("lw_reqclr", 32'(out_mem_req), 32'd0);
    tick();
    check("lw_cdbt_1cyc", 32'(out_ls_cdb_rob_tag), 32'd0);
    check("lw_cdbv_1cyc", out_ls_cdb_value, 32'd0);

    // Extension modes
    do_load(F3_LB,  5'd4, 32'h00000080, 32'hFFFFFF80, "lb");
    do_load(F3_LBU, 5'd5, 32'h00000080, 32'h00000080, "lbu");
    do_load(F3_LH,  5'd6, 32'h00008001, 32'hFFFF8001, "lh");
    do_load(F3_LHU, 5'd7, 32'h00008001, 32'h00008001, "lhu");
    tick();

    // Enable low: dispatch ignored
    ena = 0;
    dispatch(0, F3_LW, 5'd2, '0, 32'h0, '0, '0, 32'h0);
    ena = 1;
    check("ena_count", 32'(dut.count), 32'd0);
    tick();
    check("ena_req", 32'(out_mem_req), 32'd0);

    // SW waiting on data via CDB then commit
    do_reset();
    dispatch(1, F3_SW, 5'd5, '0, 32'h200, 5'd7, 32'h0, 32'd8);
    in_cdb_rob_tag = 5'd7; in_cdb_value = 32'h55;
    tick();
    in_cdb_rob_tag = '0; in_cdb_value = '0;
    check("sw_nocommit", 32'(out_mem_req), 32'd0);
    in_committed_rob_tag = 5'd5;
    tick();
    in_committed_rob_tag = '0;
    check("sw_req_lat", 32'(out_mem_req), 32'd0);
    tick();
    check("sw_req",  32'(out_mem_req), 32'd1);
    check("sw_we",   32'(out_mem_we), 32'd1);
    check("sw_addr", out_mem_addr, 32'h208);
    check("sw_data", out_mem_data, 32'h55);
    respond(32'h0);
    check("sw_nocdb", 32'(out_ls_cdb_rob_tag), 32'd0);
    check("sw_count", 32'(dut.count), 32'd0);
    tick(); tick(); tick();
    check("sw_noreissue", 32'(out_mem_req), 32'd0);
    check("sw_writes", 32'(wr_count), 32'd1);

    // Misbranch with committed store at head and two loads behind it
    do_reset();
    dispatch(1, F3_SW, 5'd9, '0, 32'h300, '0, 32'h77, 32'd0);
    in_committed_rob_tag = 5'd9;
    dispatch(0, F3_LW, 5'd10, '0, 32'h400, '0, '0, 32'd0);
    in_committed_rob_tag = '0;
    dispatch(0, F3_LW, 5'd11, '0, 32'h500, '0, '0, 32'd0);
    check("mb_req",    32'(out_mem_req), 32'd1);
    check("mb_addr",   out_mem_addr, 32'h300);
    check("mb_count3", 32'(dut.count), 32'd3);
    in_misbranch = 1;
    tick();
    in_misbranch = 0;
    check("mb_count1", 32'(dut.count), 32'd1);
    check("mb_tail",   32'(dut.tail), 32'd1);
    respond(32'h0);
    check("mb_writes", 32'(wr_count), 32'd2);
    check("mb_count0", 32'(dut.count), 32'd0);
    tick(); tick(); tick(); tick();
    check("mb_noload", 32'(out_mem_req), 32'd0);
    check("mb_nocdb",  32'(out_ls_cdb_rob_tag), 32'd0);

    // Misbranch while a load is in flight: result discarded
    dispatch(0, F3_LW, 5'd6, '0, 32'h80, '0, '0, 32'd0);
    tick();
    check("mbl_req", 32'(out_mem_req), 32'd1);
    in_misbranch = 1;
    tick();
    in_misbranch = 0;
    check("mbl_count", 32'(dut.count), 32'd0);
    respond(32'h1234);
    check("mbl_nocdb", 32'(out_ls_cdb_rob_tag), 32'd0);
    check("mbl_reqclr", 32'(out_mem_req), 32'd0);

    // Fill to LSQ_SIZE-1, pop one, wrap tail, drain in order
    do_reset();
    for (int k = 1; k <= 15; k++) begin
      dispatch(0, F3_LW, ROB_WIDTH'(k), '0, 32'h1000, '0, '0, 32'(k));
      if (k == 14) check("full_ok14", 32'(out_lsq_ok), 32'd1);
      if (k == 15) check("full_ok15", 32'(out_lsq_ok), 32'd0);
    end
    check("full_count", 32'(dut.count), 32'd15);
    respond(32'd1);
    check("full_pop_ok",  32'(out_lsq_ok), 32'd1);
    check("full_pop_tag", 32'(out_ls_cdb_rob_tag), 32'd1);
    dispatch(0, F3_LW, 5'd16, '0, 32'h1000, '0, '0, 32'd16);
    check("wrap_tail",  32'(dut.tail), 32'd0);
    check("wrap_count", 32'(dut.count), 32'd15);
    for (int k = 2; k <= 16; k++) begin
      wait_req();
      check("drain_addr", out_mem_addr, 32'h1000 + 32'(k));
      respond(32'(k * 3));
      check("drain_tag", 32'(out_ls_cdb_rob_tag), 32'(k));
      check("drain_val", out_ls_cdb_value, 32'(k * 3));
    end
    check("drain_count", 32'(dut.count), 32'd0);

    // Asynchronous reset in the middle of a memory wait
    dispatch(0, F3_LW, 5'd8, '0, 32'h20, '0, '0, 32'd0);
    tick();
    check("ar_req_pre", 32'(out_mem_req), 32'd1);
    #2 rst = 0;
    #1;
    check("ar_req",   32'(out_mem_req), 32'd0);
    check("ar_count", 32'(dut.count), 32'd0);
    #2 rst = 1;
    tick();
    dispatch(0, F3_LW, 5'd9, '0, 32'h30, '0, '0, 32'd4);
    tick();
    check("ar_post_req",  32'(out_mem_req), 32'd1);
    check("ar_post_addr", out_mem_addr, 32'h34);
    respond(32'hCAFEF00D);
    check("ar_post_tag", 32'(out_ls_cdb_rob_tag), 32'd9);
    check("ar_post_val", out_ls_cdb_value, 32'hCAFEF00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ls_queue.md
LS_QUEUE -- requirements
Module: ls_queue

Interface
REQ-001 SHALL have parameter LSQ_SIZE, default 16: number of queue entries, a power of two.
REQ-002 SHALL have ports clk in 1 (rising-edge clock) and rst in 1 (reset, asynchronous and active-low).
REQ-003 SHALL have port ena in 1: global advance enable; when low, all state holds.
REQ-004 SHALL have dispatch inputs from the decoder:
- in_assign_ena 1
- in_is_store 1
- in_funct3 3
- in_rob_tag ROB_WIDTH
- in_base_tag ROB_WIDTH / in_base_value DATA_WIDTH
- in_data_tag ROB_WIDTH / in_data_value DATA_WIDTH
- in_imm DATA_WIDTH
REQ-005 SHALL have output out_lsq_ok 1: the queue accepts a dispatch next cycle.
REQ-006 SHALL have ALU CDB snoop inputs in_cdb_rob_tag ROB_WIDTH and in_cdb_value DATA_WIDTH; tag 0 means none.
REQ-007 SHALL have input in_committed_rob_tag ROB_WIDTH (store commit from ROB, 0 = none) and input in_misbranch 1.
REQ-008 SHALL have memory port outputs out_mem_req 1, out_mem_we 1, out_mem_addr DATA_WIDTH, out_mem_data DATA_WIDTH, out_mem_size 2 (0=byte, 1=half, 2=word), and inputs in_mem_done 1, in_mem_rdata DATA_WIDTH.
REQ-009 SHALL have load result outputs to the ROB/RS: out_ls_cdb_rob_tag ROB_WIDTH and out_ls_cdb_value DATA_WIDTH.

Function
REQ-010 SHALL be a circular FIFO with head, tail and count; it SHALL dispatch at tail on in_assign_ena and wrap from LSQ_SIZE-1 to 0.
REQ-011 SHALL drive out_lsq_ok = (count < LSQ_SIZE-1), combinationally, leaving one slot for the registered decoder.
REQ-012 SHALL treat an operand as ready when its tag is 0; on a CDB tag match (ALU or own ls CDB) it SHALL capture the value and clear the tag, including for an entry dispatched in the same cycle.
REQ-013 SHALL set an entry's committed flag when in_committed_rob_tag equals its rob tag and it is a store.
REQ-014 SHALL run FSM IDLE->WAIT_MEM when the head is issuable, and WAIT_MEM->IDLE on in_mem_done. Issuable means:
- load: base ready;
- store: base and data ready and committed.
REQ-015 SHALL, on issue, register out_mem_req=1, out_mem_addr=base+imm (mod 2^32), out_mem_size=funct3[1:0], out_mem_we=is_store, and out_mem_data=data; it SHALL hold these until in_mem_done, then clear out_mem_req.
REQ-016 SHALL, on load done, pop the head and broadcast the rob tag plus the extended value for exactly one cycle the following cycle. Extension SHALL be sign for LB/LH (funct3 0/1), zero for LBU/LHU (4/5), and none for LW.
REQ-017 SHALL, on store done, pop the head without any broadcast.
REQ-018 SHALL issue strictly in order from the head only, with at most one memory transaction outstanding.
REQ-019 SHALL, on in_misbranch, discard every uncommitted entry, setting tail = head + (number of contiguous committed stores from head) and count accordingly; flush SHALL take priority over a simultaneous dispatch, which is dropped.
REQ-020 SHALL, on a flush during WAIT_MEM for a load, finish the transaction and discard the result with no broadcast; an in-flight committed store SHALL complete normally.
REQ-021 SHALL let pop and dispatch in the same cycle leave count unchanged.
REQ-022 SHALL drive out_ls_cdb_rob_tag=0 and out_ls_cdb_value=0 in every cycle without a broadcast.

Reset
REQ-023 SHALL, while rst is low, asynchronously set head=tail=count=0, FSM=IDLE, clear all valid and committed flags, and zero out_mem_req, out_mem_we, out_mem_addr, out_mem_data, out_mem_size, out_ls_cdb_rob_tag and out_ls_cdb_value.
REQ-024 SHALL abandon any memory transaction in progress when reset asserts; the memory controller is reset by the same rst.

Structure
REQ-025 SHALL take DATA_WIDTH, ROB_WIDTH, ZERO_ROB, funct3 load/store codes and memory-size codes from the shared constant file; LSQ_SIZE stays local.
REQ-026 SHALL place the load extension in one combinational sub-module, load_extend (funct3, raw data -> extended data).

Verification
REQ-027 SHALL pass: LW, base=0x100 ready, imm=4, rob 3; mem returns 0xDEADBEEF after 2 cycles -> addr 0x104, size 2, we=0, then ls CDB tag 3 value 0xDEADBEEF for one cycle.
REQ-028 SHALL pass: LB rdata 0x00000080 -> 0xFFFFFF80; LBU same rdata -> 0x00000080; LH 0x00008001 -> 0xFFFF8001.
REQ-029 SHALL pass: SW rob 5, data tag 7 pending; CDB tag 7 value 0x55, then commit tag 5 -> exactly one write, addr base+imm, data 0x55, no ls CDB.
REQ-030 SHALL pass: committed store at head, plus two uncommitted loads; misbranch -> count=1, store still written, loads never issue.
REQ-031 SHALL pass: dispatch LSQ_SIZE-1 entries with no memory response -> out_lsq_ok low at count 15, high again the cycle after the first pop; tail wraps to index 0 correctly.
REQ-032 SHALL pass: rst low mid-WAIT_MEM -> out_mem_req=0 immediately, count=0, and the first post-reset load issues normally.
